// File: rtl/aes_key_expander_pkg.sv
// Shared definitions for the iterative AES key schedule: key length
// encodings, per-mode word counts and GF(2^8) helper arithmetic.
package aes_key_expander_pkg;

  typedef enum logic [1:0] {
    KL_128  = 2'b00,
    KL_192  = 2'b01,
    KL_256  = 2'b10,
    KL_RSVD = 2'b11
  } key_len_e;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  localparam logic [5:0] WORDS_128 = 6'd44;
  localparam logic [5:0] WORDS_192 = 6'd52;
  localparam logic [5:0] WORDS_256 = 6'd60;

  localparam logic [7:0] RCON_INIT = 8'h01;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) begin
        acc = acc ^ aa;
      end else begin
        acc = acc;
      end
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // Key length in 32-bit words; 0 marks the reserved encoding.
  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return NK_128;
      KL_192:  return NK_192;
      KL_256:  return NK_256;
      default: return 4'd0;
    endcase
  endfunction

  // Number of cipher rounds for a key length.
  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return NR_128;
      KL_192:  return NR_192;
      KL_256:  return NR_256;
      default: return 4'd0;
    endcase
  endfunction

  // Total schedule words for a key length.
  function automatic logic [5:0] words_of(input logic [1:0] kl);
    case (kl)
      KL_128:  return WORDS_128;
      KL_192:  return WORDS_192;
      KL_256:  return WORDS_256;
      default: return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Key-load handshake, status and round-key read bus of the key expander.
interface aes_key_expander_if #(parameter int MAX_NK = 8);

  logic                    key_valid;
  logic                    key_ready;
  logic [1:0]              key_len;
  logic [0:32*MAX_NK-1]    key_in;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic [3:0]              rounds_ready;
  logic [3:0]              rd_addr;
  logic [0:127]            rd_data;

  modport master (
    output key_valid, key_len, key_in, rd_addr,
    input  key_ready, busy, done, err, rounds_ready, rd_data
  );

  modport slave (
    input  key_valid, key_len, key_in, rd_addr,
    output key_ready, busy, done, err, rounds_ready, rd_data
  );

endinterface

// File: rtl/aes_key_expander_sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform. Purely combinational.
module aes_key_expander_sbox
  import aes_key_expander_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // x^254 is the inverse for nonzero x and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int k = 0; k < 7; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  logic [7:0] inv_s;

  // Inverse then affine map with constant 0x63.
  always_comb begin
    inv_s    = gf_inv(in_byte);
    out_byte = inv_s ^ rotl8(inv_s, 1) ^ rotl8(inv_s, 2) ^ rotl8(inv_s, 3)
             ^ rotl8(inv_s, 4) ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule: one word per clock into a 60-word
// buffer, with a running count of complete round keys gating the read port.
module aes_key_expander
  import aes_key_expander_pkg::*;
#(
  parameter int MAX_NK = 8
)
(
  input  logic               clk,
  input  logic               rst_n,
  aes_key_expander_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_GEN  = 2'd2;

  localparam logic [3:0] MAX_NK_L = 4'(MAX_NK);

  logic [1:0]   state_r;
  logic         busy_r;
  logic         done_r;
  logic         err_r;
  logic [3:0]   rounds_r;
  logic [0:127] rd_data_r;
  logic [31:0]  win_r [0:7];   // right-aligned: win_r[7] = w[i-1]
  logic [31:0]  buf_r [0:59];
  logic [7:0]   rcon_r;
  logic [5:0]   idx_r;         // next word index i
  logic [5:0]   last_r;        // index of the final word
  logic [3:0]   nk_r;
  logic [2:0]   cnt_r;         // words remaining until i%Nk==0

  logic [0:255] key_pad_s;
  logic [31:0]  key_win_s [0:7];
  logic [3:0]   req_nk_s;
  logic         key_ok_s;
  logic         accept_s;
  logic         reject_s;
  logic         rot_s;
  logic         sub8_s;
  logic [31:0]  w_prev_s;
  logic [31:0]  w_back_s;
  logic [31:0]  sub_in_s;
  logic [31:0]  sub_out_s;
  logic [31:0]  temp_s;
  logic [31:0]  w_new_s;
  logic [5:0]   row_s;

  // Left-justify narrower key ports into a full 8-word view.
  if (MAX_NK == 8) begin : g_full
    assign key_pad_s = bus.key_in;
  end else begin : g_pad
    assign key_pad_s = {bus.key_in, {(256 - 32*MAX_NK){1'b0}}};
  end

  // Handshake decode: accept legal key lengths only while idle.
  always_comb begin
    req_nk_s = nk_of(bus.key_len);
    key_ok_s = (req_nk_s != 4'd0) && (req_nk_s <= MAX_NK_L);
    accept_s = bus.key_valid && !busy_r && key_ok_s;
    reject_s = bus.key_valid && !busy_r && !key_ok_s;
  end

  // Place the offered key into the right-aligned window layout.
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      key_win_s[j] = 32'h0;
    end
    case (req_nk_s)
      4'd4: begin
        for (int j = 0; j < 4; j++) key_win_s[4+j] = key_pad_s[32*j +: 32];
      end
      4'd6: begin
        for (int j = 0; j < 6; j++) key_win_s[2+j] = key_pad_s[32*j +: 32];
      end
      default: begin
        for (int j = 0; j < 8; j++) key_win_s[j] = key_pad_s[32*j +: 32];
      end
    endcase
  end

  // Next schedule word from w[i-1], w[i-Nk], Rcon and SubWord.
  always_comb begin
    w_prev_s = win_r[7];
    case (nk_r)
      4'd4:    w_back_s = win_r[4];
      4'd6:    w_back_s = win_r[2];
      default: w_back_s = win_r[0];
    endcase
    rot_s    = (cnt_r == 3'd0);
    sub8_s   = (nk_r == 4'd8) && (idx_r[2:0] == 3'd4);
    sub_in_s = rot_s ? {w_prev_s[23:0], w_prev_s[31:24]} : w_prev_s;
    if (rot_s) begin
      temp_s = sub_out_s ^ {rcon_r, 24'h0};
    end else if (sub8_s) begin
      temp_s = sub_out_s;
    end else begin
      temp_s = w_prev_s;
    end
    w_new_s = w_back_s ^ temp_s;
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_key_expander_sbox u_sbox (
      .in_byte  (sub_in_s[8*b +: 8]),
      .out_byte (sub_out_s[8*b +: 8])
    );
  end

  // Control FSM, sliding window, Rcon and round-key count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      rounds_r <= 4'd0;
      rcon_r   <= 8'h00;
      idx_r    <= 6'd0;
      last_r   <= 6'd0;
      nk_r     <= 4'd0;
      cnt_r    <= 3'd0;
      for (int j = 0; j < 8; j++) win_r[j] <= 32'h0;
    end else begin
      done_r <= 1'b0;
      err_r  <= reject_s;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r  <= ST_LOAD;
            busy_r   <= 1'b1;
            nk_r     <= req_nk_s;
            last_r   <= words_of(bus.key_len) - 6'd1;
            idx_r    <= {2'b00, req_nk_s};
            cnt_r    <= 3'd0;
            rcon_r   <= RCON_INIT;
            rounds_r <= req_nk_s >> 2;
            for (int j = 0; j < 8; j++) win_r[j] <= key_win_s[j];
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD, ST_GEN: begin
          for (int j = 0; j < 7; j++) win_r[j] <= win_r[j+1];
          win_r[7] <= w_new_s;
          idx_r    <= idx_r + 6'd1;
          cnt_r    <= rot_s ? 3'(nk_r - 4'd1) : cnt_r - 3'd1;
          rcon_r   <= rot_s ? xtime(rcon_r) : rcon_r;
          rounds_r <= (idx_r[1:0] == 2'b11) ? rounds_r + 4'd1 : rounds_r;
          if (idx_r == last_r) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_GEN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Round-key buffer: key words on load, one generated word per cycle after.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int j = 0; j < 8; j++) begin
        if (4'(j) < req_nk_s) buf_r[j] <= key_pad_s[32*j +: 32];
      end
    end else if (busy_r) begin
      buf_r[idx_r] <= w_new_s;
    end
  end

  assign row_s = {bus.rd_addr, 2'b00};

  // Registered read; rows not yet complete read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= 128'h0;
    end else if (bus.rd_addr < rounds_r) begin
      rd_data_r <= {buf_r[row_s], buf_r[row_s + 6'd1],
                    buf_r[row_s + 6'd2], buf_r[row_s + 6'd3]};
    end else begin
      rd_data_r <= 128'h0;
    end
  end

  assign bus.key_ready    = ~busy_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.err          = err_r;
  assign bus.rounds_ready = rounds_r;
  assign bus.rd_data      = rd_data_r;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed test of the AES key expander against FIPS-197 Appendix A vectors.
module tb_aes_key_expander;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] A1_RK0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_RK3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
  localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] A2_RK1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [127:0] A2_RK12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] A3_RK0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] A3_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] A3_RK3  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
  localparam logic [127:0] A3_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errs   = 0;
  int   mono_bad = 0;

  always #5 clk = ~clk;

  aes_key_expander_if #(.MAX_NK(8)) bus ();
  aes_key_expander_if #(.MAX_NK(4)) bus4 ();

  aes_key_expander #(.MAX_NK(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  aes_key_expander #(.MAX_NK(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Key offered for exactly one edge unless the caller keeps key_valid high.
  task automatic offer(input logic [1:0] len, input logic [255:0] key);
    bus.key_valid = 1'b1;
    bus.key_len   = len;
    bus.key_in    = key;
    tick();
  endtask

  // Counts edges after the accept edge until done is seen (bounded).
  task automatic wait_done(input string tag, input int exp_n);
    int k;
    logic [3:0] prev;
    k    = 0;
    prev = bus.rounds_ready;
    while (bus.done !== 1'b1 && k < 200) begin
      tick();
      k++;
      if (bus.rounds_ready < prev) mono_bad++;
      prev = bus.rounds_ready;
    end
    check(tag, 128'(k), 128'(exp_n));
  endtask

  task automatic read(input logic [3:0] a, input string tag, input logic [127:0] exp);
    bus.rd_addr = a;
    tick();
    check(tag, bus.rd_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_len    = 2'b00;
    bus.key_in     = 256'h0;
    bus.rd_addr    = 4'd0;
    bus4.key_valid = 1'b0;
    bus4.key_len   = 2'b00;
    bus4.key_in    = 128'h0;
    bus4.rd_addr   = 4'd0;
    repeat (3) tick();
    check("rst_key_ready", bus.key_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_rounds", bus.rounds_ready, 4'd0);
    check("rst_rd_data", bus.rd_data, 128'h0);
    rst_n = 1'b1;
    tick();

    // Reserved key_len, and AES-256 on a MAX_NK=4 instance
    bus.key_valid  = 1'b1;
    bus.key_len    = 2'b11;
    bus4.key_valid = 1'b1;
    bus4.key_len   = 2'b10;
    tick();
    check("rsvd_err", bus.err, 1'b1);
    check("rsvd_busy", bus.busy, 1'b0);
    check("rsvd_rounds", bus.rounds_ready, 4'd0);
    check("nk4_err", bus4.err, 1'b1);
    check("nk4_busy", bus4.busy, 1'b0);
    bus.key_valid = 1'b0;
    bus4.key_len  = 2'b00;
    tick();
    check("rsvd_err_pulse", bus.err, 1'b0);
    check("nk4_128_accept", bus4.busy, 1'b1);
    check("nk4_128_err", bus4.err, 1'b0);
    bus4.key_valid = 1'b0;

    // AES-128 with key_valid held high through the whole expansion
    offer(2'b00, K128);
    check("a1_busy", bus.busy, 1'b1);
    check("a1_key_ready", bus.key_ready, 1'b0);
    check("a1_load_rounds", bus.rounds_ready, 4'd1);
    wait_done("a1_done_lat", 40);
    check("a1_rounds", bus.rounds_ready, 4'd11);
    check("a1_idle", bus.busy, 1'b0);
    check("a1_ready", bus.key_ready, 1'b1);
    tick();
    check("hold_reaccept_busy", bus.busy, 1'b1);
    check("hold_reaccept_rounds", bus.rounds_ready, 4'd1);
    bus.key_valid = 1'b0;

    // Early read of round 3 while the second AES-128 run is in flight
    bus.rd_addr = 4'd3;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("early_rd3_k%0d", k), bus.rd_data, (k >= 13) ? A1_RK3 : 128'h0);
      if (k == 11) check("early_rounds_k11", bus.rounds_ready, 4'd3);
      if (k == 12) check("early_rounds_k12", bus.rounds_ready, 4'd4);
    end
    wait_done("a1b_done_rest", 24);
    read(4'd10, "a1_rk10", A1_RK10);
    read(4'd0, "a1_rk0", A1_RK0);
    read(4'd1, "a1_rk1", A1_RK1);
    read(4'd11, "a1_rk11_gated", 128'h0);

    // AES-192
    offer(2'b01, K192);
    bus.key_valid = 1'b0;
    check("a2_load_rounds", bus.rounds_ready, 4'd1);
    wait_done("a2_done_lat", 46);
    check("a2_rounds", bus.rounds_ready, 4'd13);
    read(4'd12, "a2_rk12", A2_RK12);
    read(4'd1, "a2_rk1", A2_RK1);
    read(4'd13, "a2_rk13_gated", 128'h0);

    // AES-256
    offer(2'b10, K256);
    bus.key_valid = 1'b0;
    check("a3_load_rounds", bus.rounds_ready, 4'd2);
    wait_done("a3_done_lat", 52);
    check("a3_rounds", bus.rounds_ready, 4'd15);
    read(4'd14, "a3_rk14", A3_RK14);
    read(4'd3, "a3_rk3", A3_RK3);
    read(4'd2, "a3_rk2", A3_RK2);

    // Reset during an AES-256 expansion, then a clean AES-128 run
    offer(2'b10, K256);
    bus.key_valid = 1'b0;
    bus.rd_addr   = 4'd0;
    repeat (19) tick();
    check("mid_rd0", bus.rd_data, A3_RK0);
    check("mid_rounds", bus.rounds_ready, 4'd6);
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_rounds", bus.rounds_ready, 4'd0);
    check("mid_rst_rd_data", bus.rd_data, 128'h0);
    check("mid_rst_busy", bus.busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    offer(2'b00, K128);
    bus.key_valid = 1'b0;
    wait_done("post_rst_done_lat", 40);
    read(4'd10, "post_rst_rk10", A1_RK10);
    read(4'd3, "post_rst_rk3", A1_RK3);

    check("rounds_monotonic", 128'(mono_bad), 128'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
